// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared definitions for the instruction-fetch prefetch buffer.
//   XLEN        : architectural word width
//   NOP_INSTR   : instruction presented to decode when no entry is valid
//   INSTR_BYTES : PC increment between sequential instructions
//   fetch_entry_t : one buffered fetch, {pc, instr} (64 bits)
package fetch_prefetch_buffer_pkg;

    localparam int unsigned XLEN        = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_prefetch_buffer_fifo.sv
// fetch_fifo: synchronous DEPTH x 64-bit FIFO of fetch entries.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset
//   flush_i     : empties the FIFO; overrides push and pop
//   push_i      : write push_data_i at the tail (caller guarantees space or a same-cycle pop)
//   push_data_i : entry to write
//   pop_i       : remove the head entry (ignored when empty)
//   count_o     : number of valid entries
//   head_o      : head entry, read combinationally from registered storage
module fetch_fifo
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  fetch_entry_t    push_data_i,
    input  logic            pop_i,
    output logic [CntW-1:0] count_o,
    output fetch_entry_t    head_o
);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_eff;
    logic            pop_eff;

    always_comb begin
        push_eff = push_i && !flush_i;
        pop_eff  = pop_i && !flush_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_eff) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_eff)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push_eff, pop_eff})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count_q covers them.
    always_ff @(posedge clk_i) begin
        if (push_eff && !rst_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: instruction-fetch front end feeding the IF/ID register.
// Issues in-order word fetches to imem, buffers {pc, instr} responses and presents
// the head entry to decode. A redirect flushes the buffer and drops in-flight responses.
//   clk, rst                        : clock and synchronous active-high reset
//   redirect_valid, redirect_pc     : taken branch/jump target from execute
//   imem_req_valid/ready/addr       : fetch request port
//   imem_rsp_valid/data             : in-order responses, no back-pressure
//   out_valid/ready                 : head entry handshake with decode
//   out_instr, out_pc, out_pc_plus_4 : head entry contents
module fetch_prefetch_buffer
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus_4
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [1:0]      outst_q, outst_d;
    logic [1:0]      drop_q, drop_d;
    logic [31:0]     last_pc_q, last_pc_d;
    logic [31:0]     last_pc_p4_q, last_pc_p4_d;

    logic [CntW-1:0] fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_ack;
    logic            push;
    logic            pop;
    logic [31:0]     inflight;

    always_comb begin
        inflight  = 32'(fifo_count) + 32'(outst_q);
        // Reserving FIFO space for every outstanding request keeps pushes overflow-free.
        credit_ok = (inflight < 32'(DEPTH)) && (32'(outst_q) < 32'(MAX_OUTSTANDING));
        imem_req_valid = !rst && !redirect_valid && credit_ok;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;

        rsp_ack = imem_rsp_valid && (outst_q != 2'd0);
        push    = imem_rsp_valid && !redirect_valid && (drop_q == 2'd0);
        out_valid = (fifo_count != '0);
        pop     = out_valid && out_ready && !redirect_valid;

        push_entry.pc    = resp_pc_q;
        push_entry.instr = imem_rsp_data;

        case ({req_fire, rsp_ack})
            2'b10:   outst_d = outst_q + 2'd1;
            2'b01:   outst_d = outst_q - 2'd1;
            default: outst_d = outst_q;
        endcase

        // A response landing in the redirect cycle is discarded directly,
        // so it is not counted again in the drop budget.
        if (redirect_valid) begin
            drop_d = rsp_ack ? (outst_q - 2'd1) : outst_q;
        end else if (imem_rsp_valid && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
        end else begin
            drop_d = drop_q;
        end

        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            resp_pc_d  = align_pc(redirect_pc);
        end else begin
            fetch_pc_d = req_fire ? (fetch_pc_q + 32'(INSTR_BYTES)) : fetch_pc_q;
            resp_pc_d  = push ? (resp_pc_q + 32'(INSTR_BYTES)) : resp_pc_q;
        end

        // Decode sees the last head PC held while the buffer is empty.
        last_pc_d    = last_pc_q;
        last_pc_p4_d = last_pc_p4_q;
        if (out_valid) begin
            last_pc_d    = fifo_head.pc;
            last_pc_p4_d = fifo_head.pc + 32'(INSTR_BYTES);
        end

        out_instr     = out_valid ? fifo_head.instr : NOP_INSTR;
        out_pc        = out_valid ? fifo_head.pc : last_pc_q;
        out_pc_plus_4 = out_valid ? (fifo_head.pc + 32'(INSTR_BYTES)) : last_pc_p4_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            outst_q      <= 2'd0;
            drop_q       <= 2'd0;
            last_pc_q    <= 32'h0;
            last_pc_p4_q <= 32'h0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            last_pc_q    <= last_pc_d;
            last_pc_p4_q <= last_pc_p4_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
module tb_fetch_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus_4;

    always #5 clk = ~clk;

    fetch_prefetch_buffer #(
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus_4  (out_pc_plus_4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] req_exp_q[$];
    logic [31:0] exp_pc_q[$];

    int cyc = 0;
    int lat = 1;
    bit req_ready_en = 1'b1;
    int hs_count = 0;
    int first_pop = -1;
    int last_pop = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // imem model: in-order responses with a per-request latency.
    always @(negedge clk) begin
        pend_t p;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(p.addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #2;
        imem_req_ready = req_ready_en;
        if (rst) begin
            pend_q.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            p.addr = imem_req_addr;
            p.due  = cyc + lat;
            pend_q.push_back(p);
            hs_count++;
            if (req_exp_q.size() != 0) check("req_addr", imem_req_addr, req_exp_q.pop_front());
        end
    end

    // Scoreboard monitor: compares every consumed head entry.
    always @(negedge clk) begin
        logic [31:0] e;
        #3;
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            if (exp_pc_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h expected none", out_pc);
            end else begin
                e = exp_pc_q.pop_front();
                check("out_pc", out_pc, e);
                check("out_instr", out_instr, mem_word(e));
                check("out_pc_plus_4", out_pc_plus_4, e + 32'd4);
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
    end

    task automatic drain(input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            out_ready = (exp_pc_q.size() != 0);
            if (exp_pc_q.size() == 0) break;
        end
        check("drain_left", 32'(exp_pc_q.size()), 32'd0);
        exp_pc_q.delete();
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        exp_pc_q.delete();
        req_exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        bit found;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'h0000_0013);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_pc_plus_4", out_pc_plus_4, 32'h0);

        // Fill with decode stalled, then drain at one entry per cycle
        lat = 1;
        req_exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        repeat (10) @(negedge clk);
        #1;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_out_pc", out_pc, 32'h0);
        check("full_out_pc_plus_4", out_pc_plus_4, 32'h4);
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        check("full_req_count", 32'(req_exp_q.size()), 32'd0);
        exp_pc_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};
        first_pop = -1;
        drain(40);
        check("throughput_span", 32'(last_pop - first_pop), 32'd7);

        // Two requests in flight at L=3, then redirect to 0x200
        req_ready_en = 1'b0;
        pulse_reset();
        lat = 3;
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        req_exp_q = '{32'h10, 32'h14};
        req_ready_en = 1'b1;
        base = hs_count;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        req_exp_q.push_back(32'h200);
        req_exp_q.push_back(32'h204);
        exp_pc_q = '{32'h200, 32'h204, 32'h208};
        #1;
        check("redir_req_valid", 32'(imem_req_valid), 32'd0);
        check("redir_outstanding", 32'(hs_count - base), 32'd2);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        // Both credits still held by the two stale requests this cycle
        check("post_redir_req_valid", 32'(imem_req_valid), 32'd0);
        check("post_redir_addr", imem_req_addr, 32'h200);
        drain(60);

        // Redirect coinciding with a response and a pop; target 0x103 aligns to 0x100
        pulse_reset();
        lat = 2;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (imem_rsp_valid && out_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("rsp_pop_found", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        out_ready = 1'b1;
        req_exp_q = '{32'h100, 32'h104};
        #1;
        check("rsp_redir_req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("flushed_out_valid", 32'(out_valid), 32'd0);
        check("flushed_out_instr", out_instr, 32'h0000_0013);
        check("flushed_out_pc_hold", out_pc, 32'h0);
        check("aligned_req_valid", 32'(imem_req_valid), 32'd1);
        check("aligned_req_addr", imem_req_addr, 32'h100);
        exp_pc_q = '{32'h100, 32'h104};
        drain(40);

        // Address wrap at the top of the address space
        @(negedge clk);
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        out_ready = 1'b0;
        req_exp_q = '{32'hFFFF_FFFC, 32'h0};
        @(negedge clk);
        redirect_valid = 1'b0;
        exp_pc_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        drain(40);

        // Reset while three entries are buffered
        pulse_reset();
        repeat (4) @(negedge clk);
        #1;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        req_exp_q = '{32'h0};
        #1;
        check("in_rst_req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_out_instr", out_instr, 32'h0000_0013);
        check("post_rst_out_pc", out_pc, 32'h0);
        check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_rst_req_addr", imem_req_addr, 32'h0);
        exp_pc_q = '{32'h0, 32'h4};
        drain(40);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
